fifo_width_pack_bridge: RTL
===========================

// Module: fifo_width_pack_bridge
// PURPOSE
//  Drains narrow words from the read port of an upstream FIFO and packs RATIO of them
//  into one wide word, which it writes to the write port of a downstream FIFO.
//  Pairs with the show-ahead FIFOs: rdata is valid whenever rempty is low.
//  Single clock domain, wclk.
// PARAMETERS
//  IN_WIDTH  8   width of one upstream word (>=1)
//  RATIO     4   upstream words per packed word (>=2)
//  CNTW      -   localparam, bits needed to hold the value RATIO (RATIO=4 -> 3)
// PORTS
//  wclk        in   1               clock
//  rrst        in   1               reset, asynchronous, active-high
//  in_rdata    in   IN_WIDTH        upstream FIFO rdata (show-ahead)
//  in_rempty   in   1               upstream FIFO rempty
//  in_re       out  1               upstream FIFO re (combinational)
//  out_wdata   out  IN_WIDTH*RATIO  packed word; lane 0 = bits [IN_WIDTH-1:0]
//  out_wcount  out  CNTW            valid lanes in out_wdata (1..RATIO)
//  out_we      out  1               downstream FIFO we (registered)
//  out_wfull   in   1               downstream FIFO wfull
//  flush       in   1               pulse: emit the partial word now
//  busy        out  1               partial data, pending flush or unwritten output held
// BEHAVIOUR
//  Reset values (reset is async, may assert mid-packet):
//   - out_we=0, out_wdata=0, out_wcount=0, lane index idx=0, flush_pend=0.
//   - Any partial or unwritten word is discarded.
//  Input accept:
//   - acc = in_re & ~in_rempty.
//   - in_re = ~in_rempty & ~(idx==RATIO-1 & out_we & out_wfull).
//   - in_re = 0 while rrst is high.
//  Packing:
//   - Each accepted word goes to lane idx of the pack register.
//   - idx increments, or wraps to 0 after lane RATIO-1.
//   - The first word of a packet occupies lane 0.
//  Output register:
//   - A write completes on an edge where out_we & ~out_wfull.
//   - The register is free when out_we=0 or a write completes this cycle.
//   - Last-lane accept loads out_wdata = {in_rdata, pack[lanes RATIO-2..0]},
//     out_wcount=RATIO, out_we=1.
//   - The load happens on the same edge, so latency is 1 cycle: the final input
//     word is accepted at edge N and out_we is high from N+1.
//   - Once loaded, out_we holds high with stable data/count until a write completes,
//     then drops unless a new word loads on that same edge.
//   - Full throughput: one input word per cycle, with back-to-back out_we, whenever
//     the upstream FIFO is non-empty and the downstream FIFO is not full.
//  Flush:
//   - flush sets flush_pend.
//   - When flush_pend (or flush) is set, idx>0 (counting a word accepted this cycle),
//     and the output register is free:
//     - load the partial word with out_wcount = lanes filled;
//     - zero the unused upper lanes;
//     - clear idx and flush_pend.
//   - When idx==0 and no word is accepted, flush clears flush_pend and does nothing.
//   - Flush in the same cycle as a last-lane accept: the full word is emitted normally
//     and flush_pend clears.
//   - While flush_pend waits for a free output register, input accepts continue into
//     the remaining lanes. The flush then emits whatever lanes are filled.
//  Invariant: out_wdata/out_wcount change only when out_we=0 or a write completes.
//  busy = (idx!=0) | out_we | flush_pend.
// TESTING  (IN_WIDTH=8, RATIO=4)
//  1. Stream 8'h01..8'h08, out_wfull=0:
//     - out_we for 1 cycle after the 4th and after the 8th accept;
//     - words 32'h04030201 then 32'h08070605, out_wcount=4.
//  2. Same stream, out_wfull=1 from the 4th accept for 5 cycles:
//     - 32'h04030201 held stable;
//     - in_re low only while idx==3 and the output is held;
//     - no data loss, order preserved.
//  3. Push 8'hAA, 8'hBB, then pulse flush:
//     - next cycle out_we=1, out_wdata=32'h0000BBAA, out_wcount=2;
//     - busy=0 after the write.
//  4. flush with idx=0, output idle:
//     - no out_we;
//     - busy returns to 0 the cycle after.
//  5. Assert rrst after 3 accepts and with a held full output:
//     - out_we=0 and idx=0 immediately;
//     - after release, 8'h10..8'h13 produces 32'h13121110.
//  6. Random rempty/wfull, 1000 words, periodic flush:
//     - the scoreboard rebuilds the byte stream from the lanes indicated by out_wcount;
//     - the rebuilt stream equals the input stream exactly.

Source files
------------

// File: rtl/fifo_width_pack_bridge.sv
// fifo_width_pack_bridge
// Drains narrow words from a show-ahead upstream FIFO and packs RATIO of them
// into one wide word written to a downstream FIFO. Lane 0 holds the first word
// of a packet. A flush pulse emits a partially filled word, with the lane count
// reported on out_wcount and unused upper lanes zeroed.
module fifo_width_pack_bridge #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  localparam int CNTW    = $clog2(RATIO + 1)
) (
  input  logic                        wclk,
  input  logic                        rrst,
  input  logic [IN_WIDTH-1:0]         in_rdata,
  input  logic                        in_rempty,
  output logic                        in_re,
  output logic [IN_WIDTH*RATIO-1:0]   out_wdata,
  output logic [CNTW-1:0]             out_wcount,
  output logic                        out_we,
  input  logic                        out_wfull,
  input  logic                        flush,
  output logic                        busy
);

  localparam int IDXW = $clog2(RATIO);
  localparam int OUTW = IN_WIDTH * RATIO;

  logic [IDXW-1:0]     idx;
  logic                flush_pend;
  logic [IN_WIDTH-1:0] pack [RATIO];

  logic                wr_done;
  logic                out_free;
  logic                last_lane;
  logic                acc;
  logic                flush_req;
  logic                has_data;
  logic                load;
  logic [CNTW-1:0]     fill;
  logic [OUTW-1:0]     next_word;

  // A held word at the last lane must stall the upstream read, otherwise the
  // final lane would have nowhere to go.
  assign wr_done   = out_we & ~out_wfull;
  assign out_free  = ~out_we | wr_done;
  assign last_lane = (idx == IDXW'(RATIO - 1));
  assign in_re     = ~rrst & ~in_rempty & ~(last_lane & out_we & out_wfull);
  assign acc       = in_re & ~in_rempty;
  assign flush_req = flush | flush_pend;
  assign has_data  = (idx != '0) | acc;

  // A last-lane accept always finds the register free (in_re guarantees it),
  // so a full packet and a flushed partial word share one load path.
  assign load      = (acc & last_lane) | (flush_req & has_data & out_free);
  assign fill      = CNTW'(idx) + CNTW'(acc);
  assign busy      = (idx != '0) | out_we | flush_pend;

  // Assemble the word to load: stored lanes below idx, the word being accepted
  // this cycle at lane idx, zeros above.
  always_comb begin
    next_word = '0;
    for (int l = 0; l < RATIO; l++) begin
      if (l < int'(idx)) begin
        next_word[l*IN_WIDTH +: IN_WIDTH] = pack[l];
      end else if (acc && (l == int'(idx))) begin
        next_word[l*IN_WIDTH +: IN_WIDTH] = in_rdata;
      end
    end
  end

  // Lane index, pack register, pending flush and output register update.
  always_ff @(posedge wclk or posedge rrst) begin
    if (rrst) begin
      idx        <= '0;
      flush_pend <= 1'b0;
      out_we     <= 1'b0;
      out_wdata  <= '0;
      out_wcount <= '0;
      for (int l = 0; l < RATIO; l++) begin
        pack[l] <= '0;
      end
    end else if (load) begin
      out_wdata  <= next_word;
      out_wcount <= fill;
      out_we     <= 1'b1;
      idx        <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (wr_done) begin
        out_we <= 1'b0;
      end
      if (acc) begin
        pack[idx] <= in_rdata;
        idx       <= idx + IDXW'(1);
      end
      if (flush_req && !has_data) begin
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule
